// File: rtl/lsu_ctrl.sv
// Load/store unit: runs one decoded request on a valid/ready data bus and returns aligned load data.
// Optional macro LSU_TIMEOUT_EN adds an 8-bit bus-wait timeout that reports through out_err.
module lsu_ctrl #(
  parameter int ADDR_W         = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load,
  input  logic              loadu,
  input  logic              store,
  input  logic [3:0]        dwhb,
  input  logic [7:0]        mask,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [63:0]       st_data,
  input  logic [4:0]        rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [63:0]       mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [63:0]       mem_rdata,
  output logic              out_valid,
  output logic              out_wen,
  output logic [4:0]        out_rd,
  output logic [63:0]       out_data,
  output logic              out_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_reg, state_next;
  logic              store_reg, load_reg, signed_reg;
  logic [1:0]        size_reg, size_next;
  logic [7:0]        mask_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [63:0]       wdata_reg, rdata_reg;
  logic [4:0]        rd_reg;
  logic              accept, rdata_latch, timeout_hit, err_flag;
  logic [63:0]       shifted, ext_data;

  // The wait counter is 8 bits wide; limits outside 1..255 cannot be honoured.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_out_of_range
  end

  assign accept      = (state_reg == IDLE) && in_valid;
  assign rdata_latch = ((state_reg == REQ) && mem_req_ready && mem_rsp_valid) ||
                       ((state_reg == WAIT) && mem_rsp_valid);

  // Anything other than a clean one-hot size is treated as a doubleword.
  always_comb begin
    size_next = 2'd3;
    case (dwhb)
      4'b0001: size_next = 2'd0;
      4'b0010: size_next = 2'd1;
      4'b0100: size_next = 2'd2;
      default: size_next = 2'd3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      store_reg  <= 1'b0;
      load_reg   <= 1'b0;
      signed_reg <= 1'b0;
      size_reg   <= 2'd0;
      mask_reg   <= 8'd0;
      addr_reg   <= '0;
      wdata_reg  <= 64'd0;
      rd_reg     <= 5'd0;
      rdata_reg  <= 64'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        store_reg  <= store;
        load_reg   <= (load | loadu) & ~store;
        signed_reg <= load;
        size_reg   <= size_next;
        mask_reg   <= mask;
        addr_reg   <= ls_addr;
        wdata_reg  <= st_data;
        rd_reg     <= rd;
      end
      if (rdata_latch) rdata_reg <= mem_rdata;
    end
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] cnt_reg;
  logic       err_reg;

  assign timeout_hit = ((state_reg == REQ) || (state_reg == WAIT)) &&
                       (cnt_reg == 8'(TIMEOUT_CYCLES - 1));
  assign err_flag    = err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= 8'd0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= (state_next != state_reg) ? 8'd0 : cnt_reg + 8'd1;
      if (accept) err_reg <= 1'b0;
      else if (timeout_hit && state_next == DONE && !rdata_latch) err_reg <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_flag    = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    out_valid     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (load | loadu | store) ? REQ : DONE;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_next = mem_rsp_valid ? DONE : WAIT;
        else if (timeout_hit) state_next = DONE;
      end
      WAIT: begin
        if (mem_rsp_valid || timeout_hit) state_next = DONE;
      end
      DONE: begin
        out_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_req_wen   = mem_req_valid & store_reg;
  assign mem_req_addr  = mem_req_valid ? {addr_reg[ADDR_W-1:3], 3'b000} : '0;
  assign mem_req_wdata = mem_req_valid ? (wdata_reg << {addr_reg[2:0], 3'b000}) : 64'd0;
  assign mem_req_wmask = mem_req_wen ? mask_reg : 8'd0;

  // Lanes shifted past byte 7 fall off; misaligned accesses are never split.
  assign shifted = rdata_reg >> {addr_reg[2:0], 3'b000};

  always_comb begin
    ext_data = shifted;
    case (size_reg)
      2'd0: ext_data = signed_reg ? {{56{shifted[7]}},  shifted[7:0]}  : {56'd0, shifted[7:0]};
      2'd1: ext_data = signed_reg ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
      2'd2: ext_data = signed_reg ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
      default: ext_data = shifted;
    endcase
  end

  assign out_wen  = out_valid & load_reg & ~err_flag;
  assign out_rd   = out_valid ? rd_reg : 5'd0;
  assign out_data = out_wen ? ext_data : 64'd0;
  assign out_err  = out_valid & err_flag;

endmodule
